// File: rtl/tpu_pkg.sv
// Shared TPU types and opcode constants used by the weight path.
package tpu_pkg;

  typedef logic [7:0]  byte_type;
  typedef logic [39:0] weight_addr_type;
  typedef logic [31:0] length_type;

  typedef struct packed {
    byte_type        opcode;
    length_type      length;
    weight_addr_type weight_addr;
  } weight_instr_type;

  localparam weight_instr_type INIT_WEIGHT_INSTR = '{opcode: 8'h00, length: 32'h0, weight_addr: 40'h0};

  // LOAD_WEIGHT is 0000_100x; bit 0 selects signed weights.
  localparam byte_type LOAD_WEIGHT_UNSIGNED = 8'h08;
  localparam byte_type LOAD_WEIGHT_SIGNED   = 8'h09;

endpackage

// File: rtl/weight_flow_controller.sv
// Streams consecutive weight rows from the weight buffer into the systolic
// array: issues buffer reads, then replays each read one cycle later as an
// array row load with a wrapping row index.
module weight_flow_controller
  import tpu_pkg::*;
#(
  parameter int MATRIX_WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  weight_instr_type instr,
  input  logic             instr_enable,
  output logic             weight_read_enable,
  output weight_addr_type  weight_buffer_addr,
  output logic             load_weight,
  output byte_type         weight_addr,
  output logic             is_weight_signed,
  output logic             busy,
  output logic             resource_busy
);

  localparam byte_type LAST_ROW = byte_type'(MATRIX_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  state_t          state_q;
  weight_addr_type readAddr_q;
  length_type      remaining_q;
  byte_type        readRow_q;
  logic            readEn_q;
  logic            load_q;
  byte_type        loadRow_q;
  logic            signed_q;
  logic            busy_q;
  logic            resBusy_q;
  byte_type        readRow_d;

  // Only opcode bit 0 (signedness) matters to this block.
  logic unusedOpcodeBits;
  assign unusedOpcodeBits = ^instr.opcode[7:1];

  // Row index that the next read will target, wrapping at the array height.
  always_comb begin
    readRow_d = readRow_q + 8'd1;
    if (readRow_q == LAST_ROW) begin
      readRow_d = '0;
    end
  end

  // Instruction FSM plus the one-stage read-to-load pipeline; frozen when enable is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      readAddr_q  <= '0;
      remaining_q <= '0;
      readRow_q   <= '0;
      readEn_q    <= 1'b0;
      load_q      <= 1'b0;
      loadRow_q   <= '0;
      signed_q    <= 1'b0;
      busy_q      <= 1'b0;
      resBusy_q   <= 1'b0;
    end else if (enable) begin
      load_q    <= readEn_q;
      loadRow_q <= readRow_q;
      case (state_q)
        IDLE: begin
          if (instr_enable) begin
            signed_q <= instr.opcode[0];
            if (instr.length != '0) begin
              state_q     <= READ;
              readEn_q    <= 1'b1;
              readAddr_q  <= instr.weight_addr;
              remaining_q <= instr.length;
              readRow_q   <= '0;
              busy_q      <= 1'b1;
              resBusy_q   <= 1'b1;
            end
          end
        end
        READ: begin
          if (remaining_q > 32'd1) begin
            readAddr_q  <= readAddr_q + 40'd1;
            remaining_q <= remaining_q - 32'd1;
            readRow_q   <= readRow_d;
          end else begin
            readEn_q    <= 1'b0;
            remaining_q <= '0;
            resBusy_q   <= 1'b0;
            state_q     <= DRAIN;
          end
        end
        DRAIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign weight_read_enable = readEn_q & enable;
  assign load_weight        = load_q & enable;
  assign weight_buffer_addr = readAddr_q;
  assign weight_addr        = loadRow_q;
  assign is_weight_signed   = signed_q;
  assign busy               = busy_q;
  assign resource_busy      = resBusy_q;

endmodule

// File: tb/tb_weight_flow_controller.sv
// Self-checking bench for weight_flow_controller: directed scenarios followed
// by random instructions, compared every cycle against a transaction model.
module tb_weight_flow_controller;
  import tpu_pkg::*;

  localparam int MW = 14;

  logic             clk;
  logic             rst;
  logic             enable;
  weight_instr_type instr;
  logic             instr_enable;
  logic             weight_read_enable;
  weight_addr_type  weight_buffer_addr;
  logic             load_weight;
  byte_type         weight_addr;
  logic             is_weight_signed;
  logic             busy;
  logic             resource_busy;

  int checks = 0;
  int errors = 0;

  // Model: an accepted instruction is described by base, length and the
  // number of enabled edges n elapsed since acceptance. Read k happens at
  // n == k, its load at n == k+1; the instruction is over once n > length.
  bit      mActive;
  longint  mN;
  longint  mLen;
  logic [39:0] mBase;
  bit      mSigned;

  weight_flow_controller #(.MATRIX_WIDTH(MW)) dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .instr              (instr),
    .instr_enable       (instr_enable),
    .weight_read_enable (weight_read_enable),
    .weight_buffer_addr (weight_buffer_addr),
    .load_weight        (load_weight),
    .weight_addr        (weight_addr),
    .is_weight_signed   (is_weight_signed),
    .busy               (busy),
    .resource_busy      (resource_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit modelBusy();
    return mActive && (mN <= mLen);
  endfunction

  task automatic modelReset();
    mActive = 1'b0;
    mN      = 0;
    mLen    = 0;
    mBase   = '0;
    mSigned = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs applied before it.
  task automatic modelEdge();
    bit accepted;
    accepted = enable && instr_enable && !modelBusy();
    if (enable && modelBusy()) mN++;
    if (mActive && mN > mLen) mActive = 1'b0;
    if (accepted) begin
      mSigned = instr.opcode[0];
      if (instr.length != 0) begin
        mActive = 1'b1;
        mBase   = instr.weight_addr;
        mLen    = longint'(instr.length);
        mN      = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    bit expRead, expLoad;
    logic [39:0] expAddr;
    byte_type expRow;
    expRead = mActive && (mN < mLen) && enable;
    expLoad = mActive && (mN >= 1) && (mN <= mLen) && enable;
    check("read_en", 64'(weight_read_enable), 64'(expRead));
    check("load", 64'(load_weight), 64'(expLoad));
    check("busy", 64'(busy), 64'(modelBusy()));
    check("res_busy", 64'(resource_busy), 64'(mActive && (mN < mLen)));
    check("signed", 64'(is_weight_signed), 64'(mSigned));
    if (expRead) begin
      expAddr = mBase + 40'(mN);
      check("buf_addr", 64'(weight_buffer_addr), 64'(expAddr));
    end
    if (expLoad) begin
      expRow = byte_type'((mN - 1) % MW);
      check("row", 64'(weight_addr), 64'(expRow));
    end
  endtask

  task automatic checkResetState();
    check("rst_read_en", 64'(weight_read_enable), 64'd0);
    check("rst_load", 64'(load_weight), 64'd0);
    check("rst_buf_addr", 64'(weight_buffer_addr), 64'd0);
    check("rst_row", 64'(weight_addr), 64'd0);
    check("rst_signed", 64'(is_weight_signed), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_res_busy", 64'(resource_busy), 64'd0);
  endtask

  // One clock cycle: drive inputs, cross the edge, check at the falling edge.
  task automatic applyStimulus(input logic en, input logic ie, input logic [7:0] op,
                               input logic [31:0] len, input logic [39:0] addr);
    enable             = en;
    instr_enable       = ie;
    instr.opcode       = op;
    instr.length       = len;
    instr.weight_addr  = addr;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 8'h00, 32'd0, 40'd0);
  endtask

  task automatic runToIdle();
    for (int i = 0; i < 300 && modelBusy(); i++) idleCycles(1);
    idleCycles(1);
  endtask

  initial begin
    logic [39:0] rAddr;
    logic [31:0] rLen;
    logic [7:0]  rOp;
    modelReset();
    rst          = 1'b0;
    enable       = 1'b0;
    instr_enable = 1'b0;
    instr        = INIT_WEIGHT_INSTR;
    @(negedge clk);
    checkResetState();
    rst = 1'b1;
    idleCycles(2);

    $display("[TB] signed load, length 15 at 0x21");
    applyStimulus(1'b1, 1'b1, LOAD_WEIGHT_SIGNED, 32'd15, 40'h21);
    runToIdle();

    $display("[TB] unsigned load with busy lockout");
    applyStimulus(1'b1, 1'b1, LOAD_WEIGHT_UNSIGNED, 32'd14, 40'h81);
    idleCycles(4);
    applyStimulus(1'b1, 1'b1, LOAD_WEIGHT_SIGNED, 32'd3, 40'h500);
    runToIdle();

    $display("[TB] stall mid-read");
    applyStimulus(1'b1, 1'b1, LOAD_WEIGHT_SIGNED, 32'd10, 40'h300);
    idleCycles(3);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, LOAD_WEIGHT_UNSIGNED, 32'd5, 40'h900);
    runToIdle();

    $display("[TB] back-to-back acceptance and address wrap");
    applyStimulus(1'b1, 1'b1, LOAD_WEIGHT_UNSIGNED, 32'd4, 40'hFF_FFFF_FFFE);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, LOAD_WEIGHT_SIGNED, 32'd2, 40'h40);
    runToIdle();

    $display("[TB] zero length");
    applyStimulus(1'b1, 1'b1, LOAD_WEIGHT_SIGNED, 32'd0, 40'h77);
    idleCycles(3);
    applyStimulus(1'b1, 1'b1, LOAD_WEIGHT_UNSIGNED, 32'd0, 40'h77);
    idleCycles(2);

    $display("[TB] asynchronous reset mid-read");
    applyStimulus(1'b1, 1'b1, LOAD_WEIGHT_SIGNED, 32'd20, 40'h1000);
    idleCycles(5);
    #2 rst = 1'b0;
    #1;
    modelReset();
    checkResetState();
    @(negedge clk);
    checkResetState();
    rst = 1'b1;
    idleCycles(3);

    $display("[TB] random instructions");
    for (int i = 0; i < 600; i++) begin
      rLen  = 32'($urandom_range(0, 30));
      rOp   = {7'b0000_100, 1'($urandom_range(0, 1))};
      rAddr = ($urandom_range(0, 3) == 0) ? (40'hFF_FFFF_FFF0 + 40'($urandom_range(0, 15)))
                                          : {8'($urandom), 32'($urandom)};
      applyStimulus(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) == 0), rOp, rLen, rAddr);
    end
    runToIdle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
